// File: rtl/lm75a_pkg.sv
// Shared types and constants for the LM75A target (and its initiator counterpart).
// Register reset values follow the LM75A datasheet power-on defaults.
package lm75a_pkg;

    localparam logic [6:0]  LM75A_ADDR = 7'h48;
    localparam logic [7:0]  CONF_RST   = 8'h00;
    localparam logic [15:0] THYST_RST  = 16'h4B00;
    localparam logic [15:0] TOS_RST    = 16'h5000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK
    } state_t;

    typedef enum logic [1:0] {
        PTR_TEMP,
        PTR_CONF,
        PTR_THYST,
        PTR_TOS
    } ptr_t;

endpackage

// File: rtl/lm75a_i2c_target_bus_cond.sv
// i2c_bus_cond: SCL/SDA synchronizer with SCL edge and START/STOP detection.
// Events are single-clk strobes, SYNC_STAGES+1 clk after the pad change; no backpressure.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;

    // Reset to the idle-bus level so releasing reset never fakes an edge on a quiet bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign o_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~o_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & o_sda;

endmodule

// File: rtl/lm75a_i2c_target.sv
// LM75A-compatible I2C target serving a snapshot of temp_in; pointer registers with LM75A_PTR_REGS_EN.
// Bit-level latency SYNC_STAGES+1 clk from pad; never stretches SCL.
module lm75a_i2c_target
    import lm75a_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = LM75A_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic        busy,
    output logic        rd_done
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_bus_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [15:0] r_snap;
    logic        r_rw;
    logic        r_ack_drv;
    logic        r_byte_sel;
    logic [7:0]  w_byte_in;
    logic [7:0]  w_rd_byte;

`ifdef LM75A_PTR_REGS_EN
    ptr_t        r_ptr;
    logic [1:0]  r_wr_idx;
    logic [7:0]  r_conf;
    logic [15:0] r_thyst;
    logic [15:0] r_tos;
`endif

    assign w_byte_in = {r_shift[6:0], w_sda};

    // r_byte_sel: 0 selects the MSB of a 16-bit register, 1 the LSB.
    always_comb begin
        w_rd_byte = r_byte_sel ? r_snap[7:0] : r_snap[15:8];
`ifdef LM75A_PTR_REGS_EN
        case (r_ptr)
            PTR_CONF:  w_rd_byte = r_conf;
            PTR_THYST: w_rd_byte = r_byte_sel ? r_thyst[7:0] : r_thyst[15:8];
            PTR_TOS:   w_rd_byte = r_byte_sel ? r_tos[7:0]   : r_tos[15:8];
            default:   ;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_snap     <= 16'h0000;
            r_rw       <= 1'b0;
            r_ack_drv  <= 1'b0;
            r_byte_sel <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            rd_done    <= 1'b0;
`ifdef LM75A_PTR_REGS_EN
            r_ptr      <= PTR_TEMP;
            r_wr_idx   <= 2'd0;
            r_conf     <= CONF_RST;
            r_thyst    <= THYST_RST;
            r_tos      <= TOS_RST;
`endif
        end else begin
            rd_done <= 1'b0;
            if (w_start) begin
                r_state <= ST_ADDR;
                r_cnt   <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_ADDR: if (w_scl_rise) begin
                        r_shift <= w_byte_in;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (w_byte_in[7:1] == DEV_ADDR) begin
                                r_state    <= ST_ADDR_ACK;
                                r_rw       <= w_byte_in[0];
                                r_ack_drv  <= 1'b0;
                                r_byte_sel <= 1'b0;
                                busy       <= 1'b1;
                                if (w_byte_in[0]) r_snap <= temp_in;
                            end else begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    // First fall drives the ACK; the second ends it and, for a read, presents bit 7.
                    ST_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            sda_oe    <= 1'b1;
                            r_ack_drv <= 1'b1;
                        end else if (r_rw) begin
                            sda_oe     <= ~w_rd_byte[7];
                            r_shift    <= {w_rd_byte[6:0], 1'b0};
                            r_cnt      <= 4'd1;
                            r_byte_sel <= 1'b1;
                            r_state    <= ST_RD_BYTE;
                        end else begin
                            sda_oe  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_state <= ST_WR_BYTE;
`ifdef LM75A_PTR_REGS_EN
                            r_wr_idx <= 2'd0;
`endif
                        end
                    end
                    ST_WR_BYTE: if (w_scl_rise) begin
                        r_shift <= w_byte_in;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_state   <= ST_WR_ACK;
                            r_ack_drv <= 1'b0;
`ifdef LM75A_PTR_REGS_EN
                            if (r_wr_idx != 2'd3) r_wr_idx <= r_wr_idx + 2'd1;
                            case (r_wr_idx)
                                2'd0: r_ptr <= ptr_t'(w_byte_in[1:0]);
                                2'd1: case (r_ptr)
                                    PTR_CONF:  r_conf        <= w_byte_in;
                                    PTR_THYST: r_thyst[15:8] <= w_byte_in;
                                    PTR_TOS:   r_tos[15:8]   <= w_byte_in;
                                    default:   ;
                                endcase
                                2'd2: case (r_ptr)
                                    PTR_THYST: r_thyst[7:0] <= w_byte_in;
                                    PTR_TOS:   r_tos[7:0]   <= w_byte_in;
                                    default:   ;
                                endcase
                                default: ;
                            endcase
`endif
                        end
                    end
                    ST_WR_ACK: if (w_scl_fall) begin
                        if (!r_ack_drv) begin
                            sda_oe    <= 1'b1;
                            r_ack_drv <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_state <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            r_cnt   <= 4'd0;
                            r_state <= ST_RD_ACK;
                        end else begin
                            sda_oe  <= ~r_shift[7];
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    ST_RD_ACK: if (w_scl_rise) begin
                        if (w_sda) begin
                            rd_done <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_shift    <= w_rd_byte;
                            r_byte_sel <= ~r_byte_sel;
                            r_cnt      <= 4'd0;
                            r_state    <= ST_RD_BYTE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lm75a_i2c_target.sv
// Bench for lm75a_i2c_target: bit-banged I2C initiator against a byte-level LM75A model.
module tb_lm75a_i2c_target;

    localparam int Q = 50;
    localparam int H = 100;
`ifdef LM75A_PTR_REGS_EN
    localparam bit PTR_EN = 1'b1;
`else
    localparam bit PTR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] temp_in;
    logic        busy;
    logic        rd_done;

    int n_vec = 0;
    int n_bad = 0;
    int rd_done_cnt = 0;
    bit oe_seen = 0;
    logic [7:0] rd_buf [0:7];

    logic [1:0]  m_ptr;
    logic [7:0]  m_conf;
    logic [15:0] m_thyst;
    logic [15:0] m_tos;

    assign sda_line = sda_m & ~sda_oe;

    lm75a_i2c_target dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .temp_in (temp_in),
        .busy    (busy),
        .rd_done (rd_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (rd_done) rd_done_cnt = rd_done_cnt + 1;
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_ptr = 2'd0; m_conf = 8'h00; m_thyst = 16'h4B00; m_tos = 16'h5000;
    endtask

    task automatic model_write(input logic [7:0] q [$]);
        if (q.size() > 0) m_ptr = q[0][1:0];
        if (q.size() > 1) begin
            if (m_ptr == 2'd1) m_conf = q[1];
            if (m_ptr == 2'd2) m_thyst[15:8] = q[1];
            if (m_ptr == 2'd3) m_tos[15:8] = q[1];
        end
        if (q.size() > 2) begin
            if (m_ptr == 2'd2) m_thyst[7:0] = q[2];
            if (m_ptr == 2'd3) m_tos[7:0] = q[2];
        end
    endtask

    function automatic logic [7:0] model_rd_byte(input int k, input logic [15:0] snap);
        logic [15:0] w;
        w = snap;
        if (PTR_EN && m_ptr == 2'd1) return m_conf;
        if (PTR_EN && m_ptr == 2'd2) w = m_thyst;
        if (PTR_EN && m_ptr == 2'd3) w = m_tos;
        return (k % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [15:0] rand_temp();
        logic [15:0] t;
        t = 16'($urandom);
        return {t[15:5], 5'b00000};
    endfunction

    // ---------------- bus initiator ----------------
    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl = 1'b1; #H; sda_m = 1'b0; #H; scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl = 1'b1; #H; sda_m = 1'b1; #H;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q; scl = 1'b1; #H; scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q; scl = 1'b1; #(H/2); b = sda_line; #(H/2); scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic nack);
        logic bt;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(bt);
            b = {b[6:0], bt};
        end
        write_bit(nack);
    endtask

    task automatic rd_body(input int n);
        for (int k = 0; k < 8; k++) rd_buf[k] = 8'h00;
        for (int k = 0; k < n; k++) read_byte(rd_buf[k], (k == n - 1));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; #100;
        n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (rd_done !== 1'b0) begin n_bad++; $display("FAIL reset_rd_done: got %b want 0", rd_done); end
        rst_n = 1'b1; model_reset(); #100;
    endtask

    task automatic test_read_basic();
        logic ack; int rc0;
        temp_in = 16'h1900; rc0 = rd_done_cnt;
        i2c_start(); write_byte(8'h91, ack);
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got %b want 0", ack); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_on: got %b want 1", busy); end
        rd_body(2);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (rd_buf[k] !== model_rd_byte(k, 16'h1900)) begin
                n_bad++; $display("FAIL basic_byte%0d: got %h want %h", k, rd_buf[k], model_rd_byte(k, 16'h1900));
            end
        end
        n_vec++; if (rd_done_cnt - rc0 !== 1) begin n_bad++; $display("FAIL basic_rd_done: got %0d pulses want 1", rd_done_cnt - rc0); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_off: got %b want 0", busy); end
        i2c_stop();
    endtask

    task automatic test_snapshot();
        logic ack; logic [7:0] b [0:2];
        temp_in = 16'h1900;
        i2c_start(); write_byte(8'h91, ack);
        read_byte(b[0], 1'b0);
        temp_in = 16'hE700;
        read_byte(b[1], 1'b0);
        read_byte(b[2], 1'b1);
        i2c_stop();
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (b[k] !== model_rd_byte(k, 16'h1900)) begin
                n_bad++; $display("FAIL snapshot_byte%0d: got %h want %h", k, b[k], model_rd_byte(k, 16'h1900));
            end
        end
    endtask

    task automatic test_addr_mismatch();
        logic ack; logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 8'h93 : 8'($urandom);
            if (a[7:1] == 7'h48) a[7:1] = 7'h49;
            oe_seen = 1'b0;
            i2c_start(); write_byte(a, ack);
            n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL mismatch_ack %h: got %b want 1", a, ack); end
            n_vec++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL mismatch_sda_driven %h: got %b want 0", a, oe_seen); end
            n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mismatch_busy %h: got %b want 0", a, busy); end
            i2c_stop();
        end
    endtask

    task automatic test_stop_mid_addr();
        logic ack;
        i2c_start();
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL stop_mid_sda_oe: got %b want 0", sda_oe); end
        // Remaining bits would complete 0x91 if the address phase had survived the STOP.
        scl = 1'b0; #Q; oe_seen = 1'b0;
        write_bit(1'b0); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
        read_bit(ack);
        n_vec++; if (ack !== 1'b1 || oe_seen !== 1'b0) begin
            n_bad++; $display("FAIL stop_mid_idle: got ack=%b driven=%b want ack=1 driven=0", ack, oe_seen);
        end
        i2c_stop();
        temp_in = rand_temp();
        i2c_start(); write_byte(8'h91, ack); rd_body(1); i2c_stop();
        n_vec++; if (ack !== 1'b0 || rd_buf[0] !== model_rd_byte(0, temp_in)) begin
            n_bad++; $display("FAIL stop_mid_recover: got ack=%b byte=%h want ack=0 byte=%h", ack, rd_buf[0], model_rd_byte(0, temp_in));
        end
    endtask

    task automatic test_repeated_start_mid_read();
        logic ack; logic bt; logic [2:0] bits;
        temp_in = 16'hFF80;
        i2c_start(); write_byte(8'h91, ack);
        bits = 3'b000;
        for (int i = 0; i < 3; i++) begin read_bit(bt); bits = {bits[1:0], bt}; end
        n_vec++; if (bits !== 3'b111) begin n_bad++; $display("FAIL rstart_first_bits: got %b want 111", bits); end
        temp_in = rand_temp();
        i2c_start(); write_byte(8'h91, ack);
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rstart_ack: got %b want 0", ack); end
        rd_body(2);
        i2c_stop();
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (rd_buf[k] !== model_rd_byte(k, temp_in)) begin
                n_bad++; $display("FAIL rstart_byte%0d: got %h want %h", k, rd_buf[k], model_rd_byte(k, temp_in));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        temp_in = 16'h1900;
        i2c_start(); write_byte(8'h91, ack);
        n_vec++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL rstmid_driving: got %b want 1", sda_oe); end
        rst_n = 1'b0; #1;
        n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rstmid_release: got %b want 0", sda_oe); end
        #19; rst_n = 1'b1; model_reset(); #40;
        i2c_stop();
        temp_in = rand_temp();
        i2c_start(); write_byte(8'h91, ack); rd_body(2); i2c_stop();
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rstmid_next_ack: got %b want 0", ack); end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (rd_buf[k] !== model_rd_byte(k, temp_in)) begin
                n_bad++; $display("FAIL rstmid_next_byte%0d: got %h want %h", k, rd_buf[k], model_rd_byte(k, temp_in));
            end
        end
    endtask

    task automatic test_random_reads();
        logic ack; int n; int rc0;
        for (int t = 0; t < 6; t++) begin
            temp_in = rand_temp(); n = $urandom_range(1, 5); rc0 = rd_done_cnt;
            i2c_start(); write_byte(8'h91, ack); rd_body(n); i2c_stop();
            n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rand%0d_ack: got %b want 0", t, ack); end
            for (int k = 0; k < n; k++) begin
                n_vec++;
                if (rd_buf[k] !== model_rd_byte(k, temp_in)) begin
                    n_bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", t, k, rd_buf[k], model_rd_byte(k, temp_in));
                end
            end
            n_vec++; if (rd_done_cnt - rc0 !== 1) begin n_bad++; $display("FAIL rand%0d_rd_done: got %0d want 1", t, rd_done_cnt - rc0); end
        end
    endtask

    // Writes a pointer plus data bytes, then reads n bytes back after a repeated START.
    task automatic test_ptr_write(input logic [7:0] wq [$], input int n, input string tag);
        logic ack;
        i2c_start(); write_byte(8'h90, ack);
        n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s_addr_ack: got %b want 0", tag, ack); end
        for (int i = 0; i < wq.size(); i++) begin
            write_byte(wq[i], ack);
            n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL %s_data%0d_ack: got %b want 0", tag, i, ack); end
        end
        model_write(wq);
        temp_in = rand_temp();
        i2c_start(); write_byte(8'h91, ack); rd_body(n); i2c_stop();
        for (int k = 0; k < n; k++) begin
            n_vec++;
            if (rd_buf[k] !== model_rd_byte(k, temp_in)) begin
                n_bad++; $display("FAIL %s_byte%0d: got %h want %h", tag, k, rd_buf[k], model_rd_byte(k, temp_in));
            end
        end
    endtask

    task automatic test_ptr_after_reset();
        rst_n = 1'b0; #40; rst_n = 1'b1; model_reset(); #100;
        test_ptr_write('{8'h02}, 2, "thyst_rst");
    endtask

    initial begin
        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; temp_in = 16'h0000;
        model_reset();
        test_reset();
        test_read_basic();
        test_snapshot();
        test_addr_mismatch();
        test_stop_mid_addr();
        test_repeated_start_mid_read();
        test_reset_mid_read();
        test_random_reads();
        test_ptr_write('{8'h03, 8'h55, 8'h80}, 2, "tos_wr");
        test_ptr_write('{8'h01, 8'($urandom), 8'($urandom), 8'($urandom)}, 3, "conf_wr");
        test_ptr_write('{8'h02, 8'($urandom), 8'($urandom)}, 4, "thyst_wr");
        test_ptr_write('{8'h00, 8'h12, 8'h34}, 2, "temp_wr");
        test_ptr_after_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
